freq_meter: RTL and testbench

Gated edge counter that measures the frequency of a slow digital signal against the system clock. It sits directly downstream of the divide-by-two clock divider and consumes its `out`. On request it counts rising edges of `sig_in` over a programmable window of clock cycles and reports the count with a one-cycle valid pulse. Its first uses are bench-level checking of divider ratios and on-chip frequency monitoring.

---
 rtl/freq_meter_pkg.sv | 25 ++
 rtl/edge_detect.sv | 64 ++++++
 rtl/freq_meter.sv | 157 +++++++++++++++
 tb/tb_freq_meter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// ============================================================================
// Module      : freq_meter_pkg
// Description : Shared definitions for the frequency meter. Holds the
//               measurement FSM state encoding and the default widths of
//               the edge-count result and the gate-window length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_meter_pkg;

    // Default result and window widths used by the top-level parameters.
    localparam int unsigned c_COUNT_WIDTH_DEF = 16;
    localparam int unsigned c_GATE_WIDTH_DEF  = 16;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage : freq_meter_pkg

`default_nettype wire

// File: rtl/edge_detect.sv
// ============================================================================
// Module      : edge_detect
// Description : Input conditioning and rising-edge detection for the
//               frequency meter.
//               Build option FREQ_METER_SYNC_EN: when defined, sig_in goes
//               through a 2-flop synchronizer before edge detection (for
//               sources asynchronous to clock). When not defined, sig_in is
//               used directly and must be synchronous to clock.
// Ports       : clock   - system clock, rising edge
//               reset_n - asynchronous active-low reset
//               sig_in  - signal under measurement
//               rise    - high for one cycle on each rising edge of the
//                         conditioned signal
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_detect
    import freq_meter_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise
);

    logic w_sig_s;
    logic r_sig_prev;

`ifdef FREQ_METER_SYNC_EN
    // Two-stage synchronizer; both stages reset low so a reset never
    // fabricates an edge on release.
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sig_s = r_sync2;
`else
    assign w_sig_s = sig_in;
`endif

    // One-cycle history of the conditioned signal.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sig_prev <= 1'b0;
        end else begin
            r_sig_prev <= w_sig_s;
        end
    end

    assign rise = w_sig_s & ~r_sig_prev;

endmodule : edge_detect

`default_nettype wire

// File: rtl/freq_meter.sv
// ============================================================================
// Module      : freq_meter
// Description : Gated edge counter. On an accepted start it counts rising
//               edges of sig_in over gate_cycles clock cycles, then reports
//               the count with a one-cycle valid pulse. The count saturates
//               at all-ones and a sticky overflow flag records any increment
//               lost to saturation.
//               Build option FREQ_METER_SYNC_EN: adds a 2-flop input
//               synchronizer inside edge_detect (window shifts by 3 cycles
//               relative to raw sig_in instead of 1).
// Parameters  : COUNT_WIDTH - width of the edge-count result
//               GATE_WIDTH  - width of the gate-window length input
// Ports       : clock       - system clock, rising edge
//               reset_n     - asynchronous active-low reset
//               start       - measurement request, sampled only in IDLE
//               gate_cycles - window length in cycles, latched on start
//               sig_in      - signal under measurement
//               busy        - high whenever the FSM is not IDLE
//               valid       - one-cycle pulse when count/overflow update
//               count       - edges seen in the last window (held)
//               overflow    - last window saturated count (held)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = c_COUNT_WIDTH_DEF,
    parameter int unsigned GATE_WIDTH  = c_GATE_WIDTH_DEF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [GATE_WIDTH-1:0]  gate_cycles,
    input  logic                   sig_in,
    output logic                   busy,
    output logic                   valid,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   overflow
);

    localparam logic [COUNT_WIDTH-1:0] c_ACC_MAX  = '1;
    localparam logic [COUNT_WIDTH-1:0] c_ACC_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [GATE_WIDTH-1:0]  c_GATE_ONE = {{(GATE_WIDTH-1){1'b0}}, 1'b1};

    state_t                   r_state;
    logic [GATE_WIDTH-1:0]    r_gate_cnt;
    logic [COUNT_WIDTH-1:0]   r_acc;
    logic                     r_ovf;
    logic                     r_busy;
    logic                     r_valid;
    logic [COUNT_WIDTH-1:0]   r_count;
    logic                     r_overflow;

    logic                     w_rise;
    logic [COUNT_WIDTH-1:0]   w_acc_next;
    logic                     w_ovf_next;

    // ------------------------------------------------------------------
    // Input conditioning and edge detection
    // ------------------------------------------------------------------
    edge_detect u_edge_detect (
        .clock   (clock),
        .reset_n (reset_n),
        .sig_in  (sig_in),
        .rise    (w_rise)
    );

    // ------------------------------------------------------------------
    // Saturating accumulator update for the current MEASURE cycle. An
    // edge arriving while the accumulator is already at all-ones is lost
    // and latched into the sticky overflow flag instead.
    // ------------------------------------------------------------------
    always_comb begin
        w_acc_next = r_acc;
        w_ovf_next = r_ovf;
        if (w_rise) begin
            if (r_acc == c_ACC_MAX) begin
                w_ovf_next = 1'b1;
            end else begin
                w_acc_next = r_acc + c_ACC_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM with registered outputs.
    // The result registers and valid are loaded on the transition into
    // DONE, so they are presented during the DONE cycle itself and the
    // final window cycle's edge is already included via w_acc_next.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_gate_cnt <= '0;
            r_acc      <= '0;
            r_ovf      <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc  <= '0;
                        r_ovf  <= 1'b0;
                        r_busy <= 1'b1;
                        if (gate_cycles != '0) begin
                            r_gate_cnt <= gate_cycles;
                            r_state    <= MEASURE;
                        end else begin
                            // Empty window: report zero straight away.
                            r_state    <= DONE;
                            r_valid    <= 1'b1;
                            r_count    <= '0;
                            r_overflow <= 1'b0;
                        end
                    end
                end

                MEASURE: begin
                    r_acc      <= w_acc_next;
                    r_ovf      <= w_ovf_next;
                    r_gate_cnt <= r_gate_cnt - c_GATE_ONE;
                    // Counter reaches zero this cycle: window complete.
                    if (r_gate_cnt == c_GATE_ONE) begin
                        r_state    <= DONE;
                        r_valid    <= 1'b1;
                        r_count    <= w_acc_next;
                        r_overflow <= w_ovf_next;
                    end
                end

                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign valid    = r_valid;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule : freq_meter

`default_nettype wire

// File: tb/tb_freq_meter.sv
// ============================================================================
// Module      : tb_freq_meter
// Description : Self-checking bench for freq_meter. Two instances (16-bit
//               and 4-bit count) see identical stimulus. A table of fixed
//               patterns with known edge counts, a few hand-written
//               sequences and randomized windows checked against an
//               edge-counting reference model over recorded input history.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freq_meter;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [15:0] gate_cycles;
    logic        sig_in;

    logic        busy16, valid16, ovf16;
    logic [15:0] count16;
    logic        busy4, valid4, ovf4;
    logic [3:0]  count4;

    int n_tests = 0;
    int n_fail  = 0;

    // Stimulus pattern: 0 hold low, 1 hold high, 2 toggle each cycle,
    // 3 period-4 square wave, 4 random bit each cycle.
    int          mode = 0;
    logic [1:0]  ph   = 2'd0;

    // Edge index and per-edge record of sig_in as seen by the DUT.
    int          cyc = 0;
    bit          hist [0:16383];

    freq_meter #(.COUNT_WIDTH(16), .GATE_WIDTH(16)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .gate_cycles (gate_cycles),
        .sig_in      (sig_in),
        .busy        (busy16),
        .valid       (valid16),
        .count       (count16),
        .overflow    (ovf16)
    );

    freq_meter #(.COUNT_WIDTH(4), .GATE_WIDTH(16)) dut4 (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .gate_cycles (gate_cycles),
        .sig_in      (sig_in),
        .busy        (busy4),
        .valid       (valid4),
        .count       (count4),
        .overflow    (ovf4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Held in reset the front end sees zeros.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (cyc + 1 < 16384)
            hist[cyc + 1] <= reset_n ? sig_in : 1'b0;
    end

    initial begin
        sig_in = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (mode)
                0: sig_in = 1'b0;
                1: sig_in = 1'b1;
                2: sig_in = ~sig_in;
                3: begin ph = ph + 2'd1; sig_in = ph[1]; end
                default: sig_in = 1'($urandom);
            endcase
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Conditioned signal value at edge e, derived from raw history.
    function automatic bit s_at(input int e);
`ifdef FREQ_METER_SYNC_EN
        return hist[e - 2];
`else
        return hist[e];
`endif
    endfunction

    // Rising edges counted by the window accepted at edge e0 of length n.
    function automatic int model_edges(input int e0, input int n);
        int c = 0;
        for (int e = e0 + 1; e <= e0 + n; e++)
            if (s_at(e) && !s_at(e - 1)) c++;
        return c;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic settle(input int m, input int cycles);
        mode = m;
        repeat (cycles) begin @(posedge clock); #1; end
    endtask

    // One complete measurement; called idle, 1ns after a rising edge.
    task automatic do_run(input string name, input int n, input bit use_model,
                          input int e16, input int o16, input int e4, input int o4);
        int e0, nv16, nv4, nb, vc, c16, f16, c4, f4, edges;
        int x16, y16, x4, y4;
        x16 = e16; y16 = o16; x4 = e4; y4 = o4;
        nv16 = 0; nv4 = 0; nb = 0; vc = -1;
        c16 = -1; f16 = -1; c4 = -1; f4 = -1;
        start = 1'b1;
        gate_cycles = 16'(n);
        @(posedge clock); #1;
        e0 = cyc;
        start = 1'b0;
        gate_cycles = 16'($urandom);
        for (int k = 0; k < n + 20; k++) begin
            @(negedge clock);
            if (valid16) begin nv16++; vc = cyc; c16 = int'(count16); f16 = int'(ovf16); end
            if (valid4)  begin nv4++;  c4 = int'(count4); f4 = int'(ovf4); end
            if (busy16) nb++;
            @(posedge clock); #1;
        end
        if (use_model) begin
            edges = model_edges(e0, n);
            x16 = (edges > 65535) ? 65535 : edges;
            y16 = (edges > 65535) ? 1 : 0;
            x4  = (edges > 15) ? 15 : edges;
            y4  = (edges > 15) ? 1 : 0;
        end
        chk({name, " valid16 pulses"}, nv16, 1);
        chk({name, " valid4 pulses"}, nv4, 1);
        chk({name, " valid latency"}, vc - e0, n);
        chk({name, " busy cycles"}, nb, n + 1);
        chk({name, " count16"}, c16, x16);
        chk({name, " overflow16"}, f16, y16);
        chk({name, " count4"}, c4, x4);
        chk({name, " overflow4"}, f4, y4);
    endtask

    typedef struct {
        int n;
        int mode;
        int e16;
        int o16;
        int e4;
        int o4;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int e0, nv, nb, c16;

        tbl[0]  = '{n: 100, mode: 2, e16: 50, o16: 0, e4: 15, o4: 1};
        tbl[1]  = '{n: 10,  mode: 2, e16: 5,  o16: 0, e4: 5,  o4: 0};
        tbl[2]  = '{n: 20,  mode: 1, e16: 0,  o16: 0, e4: 0,  o4: 0};
        tbl[3]  = '{n: 20,  mode: 0, e16: 0,  o16: 0, e4: 0,  o4: 0};
        tbl[4]  = '{n: 0,   mode: 2, e16: 0,  o16: 0, e4: 0,  o4: 0};
        tbl[5]  = '{n: 40,  mode: 3, e16: 10, o16: 0, e4: 10, o4: 0};
        tbl[6]  = '{n: 64,  mode: 3, e16: 16, o16: 0, e4: 15, o4: 1};
        tbl[7]  = '{n: 30,  mode: 2, e16: 15, o16: 0, e4: 15, o4: 0};
        tbl[8]  = '{n: 32,  mode: 2, e16: 16, o16: 0, e4: 15, o4: 1};
        tbl[9]  = '{n: 1,   mode: 0, e16: 0,  o16: 0, e4: 0,  o4: 0};
        tbl[10] = '{n: 10,  mode: 2, e16: 5,  o16: 0, e4: 5,  o4: 0};

        reset_n = 1'b0;
        start = 1'b0;
        gate_cycles = 16'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset busy", int'(busy16), 0);
        chk("reset valid", int'(valid16), 0);
        chk("reset count", int'(count16), 0);
        chk("reset overflow", int'(ovf16), 0);
        chk("reset count4", int'(count4), 0);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            settle(tbl[i].mode, 10);
            do_run($sformatf("vec%0d", i), tbl[i].n, 1'b0,
                   tbl[i].e16, tbl[i].o16, tbl[i].e4, tbl[i].o4);
        end

        // start during MEASURE (with a new gate_cycles) and during DONE
        settle(2, 10);
        nv = 0; nb = 0; c16 = -1;
        start = 1'b1;
        gate_cycles = 16'd20;
        @(posedge clock); #1;
        e0 = cyc;
        start = 1'b0;
        for (int k = 0; k < 45; k++) begin
            if (cyc == e0 + 5) begin start = 1'b1; gate_cycles = 16'd3; end
            else if (cyc == e0 + 6) start = 1'b0;
            else if (cyc == e0 + 20) start = 1'b1;
            else if (cyc == e0 + 21) start = 1'b0;
            @(negedge clock);
            if (valid16) begin nv++; c16 = int'(count16); end
            if (busy16) nb++;
            @(posedge clock); #1;
        end
        chk("ignored-start valid pulses", nv, 1);
        chk("ignored-start busy cycles", nb, 21);
        chk("ignored-start count", c16, 10);
        chk("ignored-start count held", int'(count16), 10);
        chk("ignored-start idle", int'(busy16), 0);

        // reset asserted mid-MEASURE
        start = 1'b1;
        gate_cycles = 16'd50;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) begin @(posedge clock); #1; end
        reset_n = 1'b0;
        #1;
        chk("midreset busy", int'(busy16), 0);
        chk("midreset valid", int'(valid16), 0);
        chk("midreset count", int'(count16), 0);
        chk("midreset overflow", int'(ovf16), 0);
        chk("midreset count4", int'(count4), 0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        nv = 0; nb = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clock);
            if (valid16 || valid4) nv++;
            if (busy16 || busy4) nb++;
            @(posedge clock); #1;
        end
        chk("post-reset spurious valid", nv, 0);
        chk("post-reset spurious busy", nb, 0);
        settle(2, 10);
        do_run("post-reset run", 40, 1'b0, 20, 0, 15, 1);

        // randomized windows against the reference model
        for (int i = 0; i < 15; i++) begin
            settle(4, int'($urandom_range(2, 8)));
            do_run($sformatf("rand%0d", i), int'($urandom_range(0, 60)), 1'b1, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_freq_meter

`default_nettype wire
